// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit: attopu instruction fetch stage (PC, ROM address, bubble insertion)
// Optional build macro FETCH_PERF_EN adds saturating taken/bubble counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] BUBBLE   = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  nextPCSel,
    input  logic [15:0] brAddr,
    input  logic [15:0] regPC,
    output logic [15:0] iAddr,
    output logic        iRen,
    input  logic [15:0] iData,
    output logic [15:0] instruction,
    output logic [15:0] instrPC,
    output logic        instrValid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perfTaken,
    output logic [15:0] perfBubble
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            instr_pc_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Only a real instruction may redirect; a bubble's nextPCSel is meaningless.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_pc_d = instr_pc_q;
        redirect   = 1'b0;
        if (!stall) begin
            if (state_q == RUN && (nextPCSel == 2'b01 || nextPCSel == 2'b10)) begin
                redirect   = 1'b1;
                state_d    = FLUSH;
                fetch_pc_d = (nextPCSel == 2'b01) ? (instr_pc_q + brAddr) : regPC;
            end else begin
                state_d    = RUN;
                instr_pc_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 16'd1;
            end
        end
    end

    assign iAddr       = fetch_pc_q;
    assign iRen        = ~stall;
    assign instrValid  = (state_q == RUN);
    assign instruction = instrValid ? iData : BUBBLE;
    assign instrPC     = instr_pc_q;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_taken_q, perf_bubble_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_taken_q  <= 16'h0000;
            perf_bubble_q <= 16'h0000;
        end else begin
            if (redirect && perf_taken_q != 16'hFFFF)
                perf_taken_q <= perf_taken_q + 16'd1;
            if (!stall && !instrValid && perf_bubble_q != 16'hFFFF)
                perf_bubble_q <= perf_bubble_q + 16'd1;
        end
    end

    assign perfTaken  = perf_taken_q;
    assign perfBubble = perf_bubble_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit: directed + randomized checks of fetch_unit against a model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [1:0]  sel;
    logic [15:0] br_addr, reg_pc;
    logic [15:0] i_addr, i_data, instr, instr_pc;
    logic        i_ren, instr_valid;

    logic        w_reset, w_stall;
    logic [1:0]  w_sel;
    logic [15:0] w_br, w_reg;
    logic [15:0] w_iaddr, w_idata, w_instr, w_ipc;
    logic        w_iren, w_ivalid;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_taken, perf_bubble, w_ptaken, w_pbubble;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .reset(reset), .stall(stall), .nextPCSel(sel),
        .brAddr(br_addr), .regPC(reg_pc), .iAddr(i_addr), .iRen(i_ren),
        .iData(i_data), .instruction(instr), .instrPC(instr_pc),
        .instrValid(instr_valid)
`ifdef FETCH_PERF_EN
        , .perfTaken(perf_taken), .perfBubble(perf_bubble)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .reset(w_reset), .stall(w_stall), .nextPCSel(w_sel),
        .brAddr(w_br), .regPC(w_reg), .iAddr(w_iaddr), .iRen(w_iren),
        .iData(w_idata), .instruction(w_instr), .instrPC(w_ipc),
        .instrValid(w_ivalid)
`ifdef FETCH_PERF_EN
        , .perfTaken(w_ptaken), .perfBubble(w_pbubble)
`endif
    );

    // ROM contents: ROM[a] = a + 0x100
    logic [15:0] i_data_r = 16'h0, w_idata_r = 16'h0;
    always @(posedge clk) begin
        if (i_ren)  i_data_r  <= i_addr + 16'h0100;
        if (w_iren) w_idata_r <= w_iaddr + 16'h0100;
    end
    assign i_data  = i_data_r;
    assign w_idata = w_idata_r;

    // Reference model: the next address to fetch, the instruction on display,
    // and running event counts.
    logic [15:0] m_fetch = 16'h0, m_pc = 16'h0;
    bit          m_valid = 1'b0;
    int          m_taken = 0, m_bub = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fetch <= 16'h0000;
            m_pc    <= 16'h0000;
            m_valid <= 1'b0;
            m_taken <= 0;
            m_bub   <= 0;
        end else if (!stall) begin
            if (m_valid && sel == 2'b01) begin
                m_fetch <= 16'((32'(m_pc) + 32'(br_addr)) % 65536);
                m_valid <= 1'b0;
                m_taken <= m_taken + 1;
            end else if (m_valid && sel == 2'b10) begin
                m_fetch <= reg_pc;
                m_valid <= 1'b0;
                m_taken <= m_taken + 1;
            end else begin
                if (!m_valid) m_bub <= m_bub + 1;
                m_pc    <= m_fetch;
                m_fetch <= 16'((32'(m_fetch) + 1) % 65536);
                m_valid <= 1'b1;
            end
        end
    end

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            chk("cmp_iren",  16'(i_ren), 16'(!stall));
            chk("cmp_iaddr", i_addr, m_fetch);
            chk("cmp_valid", 16'(instr_valid), 16'(m_valid));
            chk("cmp_instr", instr, m_valid ? m_pc + 16'h0100 : 16'h8000);
            if (m_valid) chk("cmp_pc", instr_pc, m_pc);
`ifdef FETCH_PERF_EN
            chk("cmp_ptaken", perf_taken, sat16(m_taken));
            chk("cmp_pbubble", perf_bubble, sat16(m_bub));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [15:0] t);
        int n = 0;
        while (!(m_valid && m_pc == t) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_pc: timeout waiting for %h", t);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; sel = 2'b00; br_addr = 16'h0; reg_pc = 16'h0;
        w_reset = 1'b1; w_stall = 1'b0; w_sel = 2'b00; w_br = 16'h0; w_reg = 16'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_cmp = 1'b1;

        // Reset release: one boot bubble, then sequential fetch from 0
        @(negedge clk);
        chk("t1_boot_valid", 16'(instr_valid), 16'h0);
        chk("t1_boot_instr", instr, 16'h8000);
        chk("t1_boot_iaddr", i_addr, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("t1_pc", instr_pc, 16'(i));
            chk("t1_instr", instr, 16'h0100 + 16'(i));
        end

        // Relative branch backwards
        wait_pc(16'h0005);
        sel = 2'b01; br_addr = 16'hFFFD;
        tick(); sel = 2'b00;
        @(negedge clk);
        chk("t2_bubble", 16'(instr_valid), 16'h0);
        chk("t2_bubble_instr", instr, 16'h8000);
        tick(); @(negedge clk);
        chk("t2_target_pc", instr_pc, 16'h0002);
        chk("t2_target_instr", instr, 16'h0102);

        // Register jump
        wait_pc(16'h0008);
        sel = 2'b10; reg_pc = 16'h0040;
        tick(); sel = 2'b00;
        @(negedge clk);
        chk("t3_bubble", 16'(instr_valid), 16'h0);
        tick(); @(negedge clk);
        chk("t3_target_pc", instr_pc, 16'h0040);
        chk("t3_target_instr", instr, 16'h0140);

        // Stall with a pending branch request
        sel = 2'b10; reg_pc = 16'h0000;
        tick(); sel = 2'b00;
        wait_pc(16'h0003);
        stall = 1'b1; sel = 2'b01; br_addr = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            tick(); @(negedge clk);
            chk("t4_iren", 16'(i_ren), 16'h0);
            chk("t4_hold_pc", instr_pc, 16'h0003);
            chk("t4_hold_instr", instr, 16'h0103);
        end
        stall = 1'b0;
        tick(); sel = 2'b00;
        @(negedge clk);
        chk("t4_bubble", 16'(instr_valid), 16'h0);
        tick(); @(negedge clk);
        chk("t4_target_pc", instr_pc, 16'h0013);

        // Reset during a branch bubble
        wait_pc(16'h0016);
        sel = 2'b01; br_addr = 16'h0100;
        tick(); sel = 2'b00;
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 16'(instr_valid), 16'h0);
        chk("t6_rst_instr", instr, 16'h8000);
        chk("t6_rst_iaddr", i_addr, 16'h0000);
`ifdef FETCH_PERF_EN
        chk("t6_rst_ptaken", perf_taken, 16'h0);
        chk("t6_rst_pbubble", perf_bubble, 16'h0);
`endif
        tick(); reset = 1'b0;
        tick(); @(negedge clk);
        chk("t6_restart_pc", instr_pc, 16'h0000);
        wait_pc(16'h0005);
        sel = 2'b01; br_addr = 16'hFFFD;
        tick(); sel = 2'b00;
        tick(); @(negedge clk);
        chk("t6_after_pc", instr_pc, 16'h0002);
`ifdef FETCH_PERF_EN
        chk("t6_ptaken", perf_taken, 16'h0001);
        chk("t6_pbubble", perf_bubble, 16'h0002);
`endif

        // Randomized traffic
        repeat (1500) begin
            stall   = ($urandom_range(0, 3) == 0);
            sel     = 2'($urandom_range(0, 3));
            br_addr = $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) - 16'd16 : 16'($urandom);
            reg_pc  = 16'($urandom);
            reset   = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; stall = 1'b0; sel = 2'b00;
        tick(); tick();
        run_cmp = 1'b0;

        // Wrap DUT: sequential wrap past 0xFFFF
        w_reset = 1'b0;
        @(negedge clk);
        chk("t5_boot_valid", 16'(w_ivalid), 16'h0);
        tick(); @(negedge clk);
        chk("t5_pc0", w_ipc, 16'hFFFE);
        chk("t5_instr0", w_instr, 16'h00FE);
        tick(); @(negedge clk);
        chk("t5_pc1", w_ipc, 16'hFFFF);
        tick(); @(negedge clk);
        chk("t5_pc2", w_ipc, 16'h0000);
        chk("t5_instr2", w_instr, 16'h0100);

        // Wrap DUT: relative branch across the top of memory
        w_reset = 1'b1;
        tick(); w_reset = 1'b0;
        tick(); tick();
        w_sel = 2'b01; w_br = 16'h0002;
        tick(); w_sel = 2'b00;
        @(negedge clk);
        chk("t5_br_bubble", 16'(w_ivalid), 16'h0);
        tick(); @(negedge clk);
        chk("t5_br_pc", w_ipc, 16'h0001);
        chk("t5_br_instr", w_instr, 16'h0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
